// File: rtl/rom_rd_pkg.sv
// Shared widths, defaults and FSM state type for the ROM burst reader.
package rom_rd_pkg;

  // ROM geometry: 1024 words of 8 bits
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  // Burst length counts 0..1024 words, so one bit wider than the address
  localparam int LEN_W = 11;

  // Output FIFO entries; two is the minimum that sustains one word per cycle
  localparam int DEF_DEPTH = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rom_burst_reader_if.sv
// Bus bundle for the ROM burst reader: request channel, ROM port,
// output stream and status.
//
// Handshake rule shared by the request and output channels: a transfer
// happens on a rising clock edge where valid and ready are both high. The
// source holds valid and its payload steady until that edge. The sink may
// raise or lower ready freely. On the output stream, valid never depends on
// ready.
interface rom_burst_reader_if;
  import rom_rd_pkg::*;

  // Request channel
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;

  // ROM port: address is registered in the reader, data arrives one cycle later
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_dataout;

  // Output stream
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Status
  logic              busy;
  logic              done;

  // Reader side
  modport slave (
    input  req_valid, req_addr, req_len, rom_dataout, out_ready,
    output req_ready, rom_address, out_valid, out_data, out_last, busy, done
  );

  // Requester / consumer / ROM side
  modport master (
    output req_valid, req_addr, req_len, rom_dataout, out_ready,
    input  req_ready, rom_address, out_valid, out_data, out_last, busy, done
  );

endinterface

// File: rtl/rom_rd_fifo.sv
// Small synchronous FIFO that holds ROM words with their end-of-burst tag.
// The head entry is presented combinationally. Pushing into a full FIFO is
// illegal; the upstream credit logic is responsible for preventing it.
module rom_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;

  // Pointer advance with explicit wrap so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // A pop on an empty FIFO is ignored
  assign w_do_pop = i_pop && (r_count != '0);

  // Storage, pointers and occupancy; storage clears so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // A push that does not coincide with a pop must find free space
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !w_do_pop && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/rom_burst_reader.sv
// Burst sequencer in front of a 1-cycle registered-read ROM.
// A request (start address, length) is accepted in IDLE. In RUN, one ROM
// address is issued per cycle whenever the output FIFO can be guaranteed
// room for the word. Each word is captured the cycle after its address is
// sampled and is streamed out through the FIFO. DRAIN waits for the last
// word to leave, then done pulses as the reader returns to IDLE.
module rom_burst_reader
  import rom_rd_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  rom_burst_reader_if.slave bus,
  output state_t            o_dbg_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CR_W  = CNT_W + 1;

  // Sequencer state and datapath registers
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_done;

  // Combinational control
  state_t            w_state_nxt;
  logic              w_done_nxt;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_pop;
  logic              w_issue;
  logic              w_final_issue;
  logic              w_credit_ok;
  logic              w_drain_empty;
  logic [CR_W-1:0]   w_used;
  logic [CR_W-1:0]   w_cap;

  // FIFO connections
  logic              w_fifo_valid;
  logic [DATA_W:0]   w_fifo_data;
  logic [CNT_W-1:0]  w_count;

  assign w_req_ready = (r_state == IDLE);
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_pop       = w_fifo_valid && bus.out_ready;

  // Credit: a word may be issued only if every word already committed (in
  // the FIFO or in flight from the ROM) plus this one fits. A pop this
  // cycle frees one slot. Sums are compared unsigned to avoid negatives.
  assign w_used      = CR_W'(w_count) + CR_W'(r_inflight);
  assign w_cap       = CR_W'(DEPTH) + CR_W'(w_pop);
  assign w_credit_ok = (w_used < w_cap);

  assign w_issue       = (r_state == RUN) && (r_remaining != '0) && w_credit_ok;
  assign w_final_issue = w_issue && (r_remaining == LEN_W'(1));

  // The burst is finished once nothing is in flight and the FIFO will be
  // empty after this cycle's pop.
  assign w_drain_empty = !r_inflight && (w_count == CNT_W'(w_pop));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and done-pulse decode
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.req_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (w_final_issue) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drain_empty) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Address pointer, remaining count and in-flight tracking. The ROM samples
  // r_ptr on the edge that ends an issue cycle, so r_ptr moves on that same
  // edge. r_inflight marks that rom_dataout holds a word to capture in the
  // next cycle. Reset clears it, so the ROM's reset-forced zero is never
  // pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr           <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr       <= bus.req_addr;
        r_remaining <= bus.req_len;
      end else if (w_issue) begin
        r_ptr       <= r_ptr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_final_issue;
    end
  end

  rom_rd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, bus.rom_dataout}),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_count (w_count)
  );

  assign bus.req_ready   = w_req_ready;
  assign bus.rom_address = r_ptr;
  assign bus.out_valid   = w_fifo_valid;
  assign bus.out_data    = w_fifo_data[DATA_W-1:0];
  assign bus.out_last    = w_fifo_data[DATA_W];
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader with a registered-read ROM model.
// The stream model turns each accepted request into the list of words it
// must produce, then checks them in order as they are handed off. It also
// derives busy, req_ready and done from request/last-beat events.
module tb_rom_burst_reader;
  import rom_rd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_burst_reader_if bus();
  state_t dbg_state;

  // ---------------- ROM model (1-cycle registered read, sync reset) ----------------
  logic [7:0] rom_mem [1024];
  logic [7:0] rom_q;
  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'((i * 37 + 11) ^ (i >> 3));
  end
  always @(posedge clk) begin
    if (rst) rom_q <= 8'h00;
    else     rom_q <= rom_mem[bus.rom_address];
  end
  assign bus.rom_dataout = rom_q;

  rom_burst_reader #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] exp_q [$];
  logic [7:0] got_q [$];
  int         hs_q  [$];
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  logic       exp_rst_vals = 1'b1;
  logic       chk_en = 1'b0;
  logic       want_first = 1'b0;
  int         acc_edge = 0;
  int         last_lat = -1;
  int         done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model for the coming edge
  always @(negedge clk) begin : cmp_proc
    logic       nb;
    logic       nd;
    logic [8:0] head;
    int         a;
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("req_ready", 32'(bus.req_ready), 32'(!exp_busy));
      chk("done", 32'(bus.done), 32'(exp_done));
      if (exp_rst_vals) begin
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_rom_address", 32'(bus.rom_address), 0);
      end
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("beat_expected", 0, 1);
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(exp_q[0][7:0]));
          chk("out_last", 32'(bus.out_last), 32'(exp_q[0][8]));
        end
      end
    end
    if (bus.done === 1'b1) done_cnt++;
    nb = exp_busy;
    nd = 1'b0;
    if (rst) begin
      exp_q.delete();
      nb = 1'b0;
      want_first = 1'b0;
      exp_rst_vals = 1'b1;
    end else begin
      exp_rst_vals = 1'b0;
      if (bus.out_valid === 1'b1 && want_first) begin
        last_lat = cyc - acc_edge;
        want_first = 1'b0;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready && exp_q.size() > 0) begin
        head = exp_q.pop_front();
        got_q.push_back(bus.out_data);
        hs_q.push_back(cyc + 1);
        if (head[8]) begin
          nd = 1'b1;
          nb = 1'b0;
        end
      end
      if (bus.req_valid && !exp_busy) begin
        if (bus.req_len == '0) begin
          nd = 1'b1;
        end else begin
          for (int i = 0; i < int'(bus.req_len); i++) begin
            a = (int'(bus.req_addr) + i) % 1024;
            exp_q.push_back({1'(i == int'(bus.req_len) - 1), rom_mem[a]});
          end
          nb = 1'b1;
          acc_edge = cyc + 1;
          want_first = 1'b1;
        end
      end
    end
    exp_busy = nb;
    exp_done = nd;
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [9:0] a, input logic [10:0] l);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed tests ----------------
  int base;
  int dc;
  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 1);
    chk("reset_dbg_state", 32'(dbg_state), 32'(IDLE));
    chk("reset_out_valid", 32'(bus.out_valid), 0);

    // 1: plain burst with ready held high
    base = got_q.size(); dc = done_cnt;
    send_req(10'h010, 11'd4);
    wait_done(20, "t1");
    chk("t1_beats", 32'(got_q.size() - base), 4);
    chk("t1_latency", 32'(last_lat), 2);
    chk("t1_span", 32'(hs_q[hs_q.size()-1] - hs_q[base]), 3);
    chk("t1_w0", 32'(got_q[base]), 32'h59);
    chk("t1_w1", 32'(got_q[base+1]), 32'h82);
    chk("t1_done_once", 32'(done_cnt - dc), 1);

    // 2: address wrap 0x3FF -> 0x000
    base = got_q.size(); dc = done_cnt;
    send_req(10'h3FE, 11'd4);
    wait_done(20, "t2");
    chk("t2_beats", 32'(got_q.size() - base), 4);
    chk("t2_w0", 32'(got_q[base]), 32'hBE);
    chk("t2_w1", 32'(got_q[base+1]), 32'h99);
    chk("t2_w2", 32'(got_q[base+2]), 32'h0B);
    chk("t2_w3", 32'(got_q[base+3]), 32'h30);
    chk("t2_done_once", 32'(done_cnt - dc), 1);

    // 3: random backpressure
    base = got_q.size(); dc = done_cnt;
    send_req(10'h123, 11'd16);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
        @(posedge clk); #1 bus.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (bus.done === 1'b1) seen = 1'b1;
      end
      chk("t3_done_seen", 32'(seen), 1);
      @(posedge clk); #1 bus.out_ready = 1'b1;
    end
    chk("t3_beats", 32'(got_q.size() - base), 16);
    chk("t3_done_once", 32'(done_cnt - dc), 1);

    // 4: zero-length burst
    base = got_q.size(); dc = done_cnt;
    send_req(10'h077, 11'd0);
    @(negedge clk);
    chk("t4_done_now", 32'(bus.done), 1);
    chk("t4_busy", 32'(bus.busy), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_beats", 32'(got_q.size() - base), 0);
    chk("t4_done_once", 32'(done_cnt - dc), 1);

    // 5: full 1024-word burst with an ignored mid-burst request
    base = got_q.size(); dc = done_cnt;
    send_req(10'h200, 11'd1024);
    repeat (500) @(posedge clk);
    #1;
    bus.req_valid = 1'b1; bus.req_addr = 10'h0AA; bus.req_len = 11'd5;
    @(negedge clk);
    chk("t5_midburst_req_ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    wait_done(1300, "t5");
    chk("t5_beats", 32'(got_q.size() - base), 1024);
    chk("t5_latency", 32'(last_lat), 2);
    chk("t5_span", 32'(hs_q[hs_q.size()-1] - hs_q[base]), 1023);
    chk("t5_first", 32'(got_q[base]), 32'h4B);
    chk("t5_w3ff", 32'(got_q[base+511]), 32'h99);
    chk("t5_w000", 32'(got_q[base+512]), 32'h0B);
    chk("t5_done_once", 32'(done_cnt - dc), 1);

    // 6: reset in the middle of a burst, then a fresh burst
    base = got_q.size(); dc = done_cnt;
    send_req(10'h040, 11'd8);
    begin
      logic got3;
      got3 = 1'b0;
      for (int k = 0; k < 60 && !got3; k++) begin
        @(negedge clk); #1;
        if (got_q.size() - base >= 3) got3 = 1'b1;
      end
      chk("t6_three_beats", 32'(got3), 1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_out_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_dbg_state", 32'(dbg_state), 32'(IDLE));
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_done", 32'(done_cnt - dc), 0);
    base = got_q.size(); dc = done_cnt;
    send_req(10'h005, 11'd2);
    wait_done(20, "t6b");
    chk("t6_beats", 32'(got_q.size() - base), 2);
    chk("t6_w0", 32'(got_q[base]), 32'hC4);
    chk("t6_w1", 32'(got_q[base+1]), 32'hE9);
    chk("t6_done_once", 32'(done_cnt - dc), 1);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_empty", 32'(exp_q.size()), 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
